axi_pwm_multi: RTL

Next-generation AXI4-Lite PWM peripheral. NUM_CH independent PWM outputs share one prescaled timebase.

---
 rtl/axi_pwm_pkg.sv | 29 ++
 rtl/pwm_timebase.sv | 35 +++
 rtl/axi_pwm_multi.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/axi_pwm_pkg.sv
// rtl/axi_pwm_pkg.sv - register map, response codes, bus FSM states and strobe merge for axi_pwm_multi
package axi_pwm_pkg;

    localparam int OFF_CTRL     = 'h00;
    localparam int OFF_STATUS   = 'h04;
    localparam int OFF_PERIOD   = 'h08;
    localparam int OFF_PRESCALE = 'h0C;
    localparam int OFF_DUTY0    = 'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;

    typedef enum logic [1:0] {WR_IDLE, WR_ACK, WR_RESP} wr_state_e;
    typedef enum logic [1:0] {RD_IDLE, RD_ACK, RD_DATA} rd_state_e;

    function automatic logic [31:0] merge_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared prescaler and period counter; wrap is combinational so shadows load on the same edge
module pwm_timebase #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] prescale,
    input  logic [CNT_W-1:0] per_act,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] psc;
    logic             tick;

    assign tick = (psc == prescale);
    assign wrap = en && tick && (cnt == per_act);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc <= '0;
            cnt <= '0;
        end else if (!en) begin
            psc <= '0;
            cnt <= '0;
        end else begin
            psc <= tick ? '0 : psc + CNT_W'(1);
            if (tick) begin
                cnt <= (cnt == per_act) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi_pwm_multi.sv
// rtl/axi_pwm_multi.sv - AXI4-Lite multi-channel PWM with double-buffered period/duty and wrap interrupt
module axi_pwm_multi
    import axi_pwm_pkg::*;
#(
    parameter int NUM_CH             = 8,
    parameter int CNT_W              = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [NUM_CH-1:0]               PWM_OUT,
    output logic                            irq
);

    wr_state_e        wr_state, wr_next;
    rd_state_e        rd_state, rd_next;
    logic [1:0]       ctrl;
    logic             wrap_pend;
    logic [CNT_W-1:0] period, prescale, per_act, cnt;
    logic [CNT_W-1:0] duty     [NUM_CH];
    logic [CNT_W-1:0] duty_act [NUM_CH];
    logic             en, wrap, wr_fire, wr_hit, rd_hit, wp_clr;
    int               wr_off, rd_off;
    logic [31:0]      wr_val, rd_val;
    logic             unused_bits;

    assign en          = ctrl[CTRL_EN];
    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], wr_val};

    function automatic logic [31:0] reg_read(input int off);
        logic [31:0] v;
        v = '0;
        if (off == OFF_CTRL)     v = 32'(ctrl);
        if (off == OFF_STATUS)   v = 32'(wrap_pend);
        if (off == OFF_PERIOD)   v = 32'(period);
        if (off == OFF_PRESCALE) v = 32'(prescale);
        for (int i = 0; i < NUM_CH; i++) begin
            if (off == OFF_DUTY0 + 4*i) v = 32'(duty[i]);
        end
        return v;
    endfunction

    always_comb begin
        wr_off  = int'({s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
        rd_off  = int'({s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2], 2'b00});
        wr_hit  = (wr_off < OFF_DUTY0 + 4*NUM_CH);
        rd_hit  = (rd_off < OFF_DUTY0 + 4*NUM_CH);
        wr_val  = merge_wstrb(reg_read(wr_off), s00_axi_wdata, s00_axi_wstrb);
        rd_val  = rd_hit ? reg_read(rd_off) : '0;
        wr_fire = (wr_state == WR_ACK);
        wp_clr  = wr_fire && (wr_off == OFF_STATUS) && s00_axi_wstrb[0] && s00_axi_wdata[0];
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    // The master holds awvalid/wvalid through WR_ACK, so the handshake completes there unconditionally.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: if (s00_axi_awvalid && s00_axi_wvalid) wr_next = WR_ACK;
            WR_ACK:  wr_next = WR_RESP;
            WR_RESP: if (s00_axi_bready) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (s00_axi_arvalid) rd_next = RD_ACK;
            RD_ACK:  rd_next = RD_DATA;
            RD_DATA: if (s00_axi_rready) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_awready = (wr_state == WR_ACK);
        s00_axi_wready  = (wr_state == WR_ACK);
        s00_axi_bvalid  = (wr_state == WR_RESP);
        s00_axi_arready = (rd_state == RD_ACK);
        s00_axi_rvalid  = (rd_state == RD_DATA);
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_bresp <= RESP_OKAY;
            s00_axi_rresp <= RESP_OKAY;
            s00_axi_rdata <= '0;
        end else begin
            if (wr_fire) s00_axi_bresp <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (rd_state == RD_ACK) begin
                s00_axi_rdata <= rd_val;
                s00_axi_rresp <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl     <= '0;
            period   <= '0;
            prescale <= '0;
            for (int i = 0; i < NUM_CH; i++) duty[i] <= '0;
        end else if (wr_fire && wr_hit) begin
            if (wr_off == OFF_CTRL)     ctrl     <= wr_val[1:0];
            if (wr_off == OFF_PERIOD)   period   <= wr_val[CNT_W-1:0];
            if (wr_off == OFF_PRESCALE) prescale <= wr_val[CNT_W-1:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_off == OFF_DUTY0 + 4*i) duty[i] <= wr_val[CNT_W-1:0];
            end
        end
    end

    pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .en       (en),
        .prescale (prescale),
        .per_act  (per_act),
        .cnt      (cnt),
        .wrap     (wrap)
    );

    // Shadows track the registers while disabled so enabling starts from the latest values.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            per_act   <= '0;
            wrap_pend <= 1'b0;
            irq       <= 1'b0;
            PWM_OUT   <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else begin
            if (!en || wrap) begin
                per_act <= period;
                for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty[i];
            end
            if (wrap)        wrap_pend <= 1'b1;
            else if (wp_clr) wrap_pend <= 1'b0;
            irq <= wrap_pend & ctrl[CTRL_IRQ_EN];
            for (int i = 0; i < NUM_CH; i++) PWM_OUT[i] <= en && (cnt < duty_act[i]);
        end
    end

endmodule
